// File: rtl/axi_stream_pkg.sv
// Shared types and constants for the stream router: FSM encoding and the
// width and saturating-increment helper for the dropped-packet counter.
package axi_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } router_state_t;

  localparam int DROP_CNT_WIDTH = 16;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    if (v == {DROP_CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/stream_router_if.sv
// Bundle of the router's input stream, per-output streams and drop counter.
interface stream_router_if
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_NUM = 2
) ();
  localparam int DEST_WIDTH = $clog2(OUTPUT_NUM);

  logic [DATA_WIDTH-1:0]     data_i;
  logic [DEST_WIDTH-1:0]     dest_i;
  logic                      last_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [DATA_WIDTH-1:0]     data_o [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0]     last_o;
  logic [OUTPUT_NUM-1:0]     valid_o;
  logic [OUTPUT_NUM-1:0]     ready_i;
  logic [DROP_CNT_WIDTH-1:0] drop_count_o;

  modport master (
    output data_i, dest_i, last_i, valid_i, ready_i,
    input  ready_o, data_o, last_o, valid_o, drop_count_o
  );

  modport slave (
    input  data_i, dest_i, last_i, valid_i, ready_i,
    output ready_o, data_o, last_o, valid_o, drop_count_o
  );
endinterface

// File: rtl/stream_router_reg.sv
// One-entry valid/ready pipeline register for a data+last payload; it can be
// loaded while draining, so a stream through it runs at full rate.
module stream_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_valid_o = valid_q;

  // Next slot contents: load wins, otherwise a drain empties the slot.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (in_valid_i && in_ready_o) begin
      data_d  = in_data_i;
      last_d  = in_last_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      data_q  <= {DATA_WIDTH{1'b0}};
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/stream_router.sv
// One-to-many packet router: locks the destination on a packet's first beat,
// steers beats into per-output slots and swallows packets to absent outputs.
module stream_router
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_NUM = 2
) (
  input logic           ACLK,
  input logic           ARESETn,
  stream_router_if.slave bus
);
  localparam int                  DEST_WIDTH = $clog2(OUTPUT_NUM);
  localparam logic [DEST_WIDTH:0] NUM_OUT    = (DEST_WIDTH+1)'(OUTPUT_NUM);

  router_state_t             state_q, state_d;
  logic [DEST_WIDTH-1:0]     dest_q, dest_d;
  logic [DEST_WIDTH-1:0]     sel_s;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      dest_ok_s, route_s, state_ready_s, ready_s, accept_s;
  logic [OUTPUT_NUM-1:0]     slot_ready_s, load_s;

  // Select the target slot and derive ready; never looks at valid_i.
  always_comb begin
    dest_ok_s     = ({1'b0, bus.dest_i} < NUM_OUT);
    sel_s         = dest_q;
    route_s       = 1'b0;
    state_ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        sel_s   = bus.dest_i;
        route_s = dest_ok_s;
        if (dest_ok_s) begin
          state_ready_s = slot_ready_s[bus.dest_i];
        end else begin
          state_ready_s = 1'b1;
        end
      end
      ROUTE: begin
        route_s       = 1'b1;
        state_ready_s = slot_ready_s[dest_q];
      end
      DROP: begin
        state_ready_s = 1'b1;
      end
      default: begin
        state_ready_s = 1'b0;
      end
    endcase
    if (!ARESETn) begin
      ready_s = 1'b0;
    end else begin
      ready_s = state_ready_s;
    end
  end

  assign accept_s         = bus.valid_i && ready_s;
  assign bus.ready_o      = ready_s;
  assign bus.drop_count_o = drop_q;

  // Route lock and drop counting advance only on an accepted beat.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (accept_s && dest_ok_s) begin
          dest_d  = bus.dest_i;
          state_d = bus.last_i ? IDLE : ROUTE;
        end else if (accept_s) begin
          drop_d  = sat_inc(drop_q);
          state_d = bus.last_i ? IDLE : DROP;
        end else begin
          state_d = IDLE;
        end
      end
      ROUTE, DROP: begin
        if (accept_s && bus.last_i) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      dest_q  <= {DEST_WIDTH{1'b0}};
      drop_q  <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_slot
    assign load_s[k] = accept_s && route_s && (sel_s == DEST_WIDTH'(k));

    stream_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .ACLK        (ACLK),
      .ARESETn     (ARESETn),
      .in_data_i   (bus.data_i),
      .in_last_i   (bus.last_i),
      .in_valid_i  (load_s[k]),
      .in_ready_o  (slot_ready_s[k]),
      .out_data_o  (bus.data_o[k]),
      .out_last_o  (bus.last_o[k]),
      .out_valid_o (bus.valid_o[k]),
      .out_ready_i (bus.ready_i[k])
    );
  end
endmodule

// File: tb/tb_stream_router.sv
// Self-checking bench for stream_router with three outputs, so dest 3 is absent.
module tb_stream_router;
  localparam int DW = 32;
  localparam int NO = 3;

  logic ACLK;
  logic ARESETn;

  stream_router_if #(.DATA_WIDTH(DW), .OUTPUT_NUM(NO)) bus ();

  stream_router #(.DATA_WIDTH(DW), .OUTPUT_NUM(NO)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: beats waiting in each output, packet lock and drop count.
  logic [32:0] exp_q [NO][$];
  bit          busy;
  int          lock;
  int          drop_m;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int route_of(input logic [1:0] d);
    if (busy) return lock;
    return (int'(d) < NO) ? int'(d) : -1;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NO; k++) begin
      check_eq($sformatf("valid_o[%0d]", k), 32'(bus.valid_o[k]), 32'(exp_q[k].size() > 0));
      if (exp_q[k].size() > 0) begin
        check_eq($sformatf("data_o[%0d]", k), bus.data_o[k], exp_q[k][0][31:0]);
        check_eq($sformatf("last_o[%0d]", k), 32'(bus.last_o[k]), 32'(exp_q[k][0][32]));
      end
    end
    check_eq("drop_count_o", 32'(bus.drop_count_o), drop_m);
  endtask

  // One clock: drive at negedge, check ready, update reference at the edge, check outputs.
  task automatic step(input logic v, input logic [1:0] d, input logic [31:0] x, input logic l,
                      input logic [NO-1:0] r, output logic rs);
    int   sel;
    logic er;
    logic acc;
    bus.valid_i = v;
    bus.dest_i  = d;
    bus.data_i  = x;
    bus.last_i  = l;
    bus.ready_i = r;
    #1;
    sel = route_of(d);
    er  = (sel < 0) ? 1'b1 : ((exp_q[sel].size() == 0) || r[sel]);
    rs  = bus.ready_o;
    check_eq("ready_o", 32'(rs), 32'(er));
    acc = v && er;
    @(posedge ACLK);
    for (int k = 0; k < NO; k++) begin
      if (r[k] && exp_q[k].size() > 0) void'(exp_q[k].pop_front());
    end
    if (acc) begin
      if (sel >= 0) exp_q[sel].push_back({l, x});
      if (!busy) begin
        if (sel < 0) drop_m = (drop_m == 65535) ? 65535 : drop_m + 1;
        lock = sel;
      end
      busy = !l;
    end
    @(negedge ACLK);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    ARESETn     = 1'b0;
    bus.valid_i = 1'b1;
    bus.dest_i  = 2'd0;
    bus.data_i  = 32'h0;
    bus.last_i  = 1'b0;
    bus.ready_i = 3'b000;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_ready_o", 32'(bus.ready_o), 32'h0);
      @(posedge ACLK);
      @(negedge ACLK);
      check_eq("rst_valid_o", 32'(bus.valid_o), 32'h0);
      check_eq("rst_last_o", 32'(bus.last_o), 32'h0);
      check_eq("rst_drop", 32'(bus.drop_count_o), 32'h0);
      for (int k = 0; k < NO; k++) check_eq("rst_data_o", bus.data_o[k], 32'h0);
    end
    for (int k = 0; k < NO; k++) exp_q[k].delete();
    busy        = 1'b0;
    lock        = -1;
    drop_m      = 0;
    ARESETn     = 1'b1;
    bus.valid_i = 1'b0;
  endtask

  initial begin
    logic rs;
    ARESETn     = 1'b0;
    bus.valid_i = 1'b0;
    bus.dest_i  = 2'd0;
    bus.data_i  = 32'h0;
    bus.last_i  = 1'b0;
    bus.ready_i = 3'b000;
    busy        = 1'b0;
    lock        = -1;
    drop_m      = 0;
    @(negedge ACLK);
    do_reset(3);

    // Locked route: dest changes mid-packet are ignored.
    step(1'b1, 2'd2, 32'hA, 1'b0, 3'b111, rs);
    check_eq("lock_a_data", bus.data_o[2], 32'hA);
    check_eq("lock_a_vld", 32'(bus.valid_o), 32'h4);
    step(1'b1, 2'd1, 32'hB, 1'b0, 3'b111, rs);
    check_eq("lock_b_data", bus.data_o[2], 32'hB);
    check_eq("lock_b_vld", 32'(bus.valid_o), 32'h4);
    step(1'b1, 2'd1, 32'hC, 1'b1, 3'b111, rs);
    check_eq("lock_c_data", bus.data_o[2], 32'hC);
    check_eq("lock_c_last", 32'(bus.last_o[2]), 32'h1);
    step(1'b0, 2'd0, 32'h0, 1'b0, 3'b111, rs);
    check_eq("lock_end_vld", 32'(bus.valid_o), 32'h0);

    // Backpressure on output 2.
    step(1'b1, 2'd2, 32'hA, 1'b0, 3'b011, rs);
    check_eq("bp_a_data", bus.data_o[2], 32'hA);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd2, 32'hB, 1'b0, 3'b011, rs);
      check_eq("bp_stall_ready", 32'(rs), 32'h0);
      check_eq("bp_hold_data", bus.data_o[2], 32'hA);
      check_eq("bp_hold_vld", 32'(bus.valid_o[2]), 32'h1);
    end
    step(1'b1, 2'd2, 32'hB, 1'b0, 3'b111, rs);
    check_eq("bp_release_ready", 32'(rs), 32'h1);
    check_eq("bp_b_data", bus.data_o[2], 32'hB);
    step(1'b1, 2'd2, 32'hC, 1'b1, 3'b111, rs);
    check_eq("bp_c_data", bus.data_o[2], 32'hC);
    step(1'b0, 2'd0, 32'h0, 1'b0, 3'b111, rs);
    check_eq("bp_end_vld", 32'(bus.valid_o), 32'h0);

    // Back-to-back single-beat packets to different outputs.
    step(1'b1, 2'd0, 32'h11, 1'b1, 3'b111, rs);
    check_eq("b2b_first_ready", 32'(rs), 32'h1);
    check_eq("b2b_first_vld", 32'(bus.valid_o), 32'h1);
    step(1'b1, 2'd1, 32'h22, 1'b1, 3'b111, rs);
    check_eq("b2b_second_ready", 32'(rs), 32'h1);
    check_eq("b2b_second_vld", 32'(bus.valid_o), 32'h2);
    check_eq("b2b_second_data", bus.data_o[1], 32'h22);
    step(1'b0, 2'd0, 32'h0, 1'b0, 3'b111, rs);
    check_eq("b2b_end_vld", 32'(bus.valid_o), 32'h0);

    // Packet to absent output 3 is swallowed and counted once.
    step(1'b1, 2'd3, 32'hDEAD, 1'b0, 3'b111, rs);
    check_eq("drop_b1_ready", 32'(rs), 32'h1);
    step(1'b1, 2'd0, 32'hBEEF, 1'b1, 3'b111, rs);
    check_eq("drop_b2_ready", 32'(rs), 32'h1);
    check_eq("drop_vld", 32'(bus.valid_o), 32'h0);
    check_eq("drop_count", 32'(bus.drop_count_o), 32'h1);
    step(1'b1, 2'd0, 32'h33, 1'b1, 3'b111, rs);
    check_eq("after_drop_vld", 32'(bus.valid_o), 32'h1);
    step(1'b0, 2'd0, 32'h0, 1'b0, 3'b111, rs);

    // Drive the counter to its ceiling with single-beat drops.
    bus.valid_i = 1'b1;
    bus.dest_i  = 2'd3;
    bus.last_i  = 1'b1;
    bus.ready_i = 3'b111;
    repeat (65534) @(negedge ACLK);
    drop_m = 65535;
    check_eq("sat_reach", 32'(bus.drop_count_o), 32'hFFFF);
    step(1'b1, 2'd3, 32'h1, 1'b0, 3'b111, rs);
    step(1'b1, 2'd1, 32'h2, 1'b1, 3'b111, rs);
    step(1'b1, 2'd3, 32'h3, 1'b1, 3'b111, rs);
    check_eq("sat_hold", 32'(bus.drop_count_o), 32'hFFFF);

    // Reset in the middle of a packet to output 1.
    step(1'b1, 2'd1, 32'h71, 1'b0, 3'b000, rs);
    check_eq("midrst_pre_vld", 32'(bus.valid_o), 32'h2);
    do_reset(1);
    step(1'b1, 2'd0, 32'h55, 1'b1, 3'b111, rs);
    check_eq("midrst_post_ready", 32'(rs), 32'h1);
    check_eq("midrst_post_vld", 32'(bus.valid_o), 32'h1);
    check_eq("midrst_post_data", bus.data_o[0], 32'h55);

    // Random traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 2) == 0, 3'($urandom), rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_router.md
# stream_router

One-to-many packet router for the on-chip stream fabric: the demultiplexing counterpart of the round-robin stream arbiter. It accepts one valid/ready stream carrying a destination index and a packet-end flag, locks the route on the first beat of each packet, and steers all beats up to and including `last` to one of `OUTPUT_NUM` registered output streams. Packets addressed to a nonexistent output are consumed and counted, never forwarded.

## Interface
- `DATA_WIDTH`, 32: payload width.
- `OUTPUT_NUM`, 2: number of output streams, ≥2.
- `DEST_WIDTH`: localparam, `$clog2(OUTPUT_NUM)`.
- `ACLK` input 1: single clock, all logic on the rising edge.
- `ARESETn` input 1: reset, synchronous and active-low.
- `data_i` input `DATA_WIDTH`: input payload.
- `dest_i` input `DEST_WIDTH`: destination index, sampled only on the first beat of a packet.
- `last_i` input 1: final beat of the packet.
- `valid_i` input 1: input beat valid.
- `ready_o` output 1: input beat accepted when `valid_i && ready_o`.
- `data_o` output `DATA_WIDTH` × `OUTPUT_NUM`: unpacked array of per-output payloads.
- `last_o` output `OUTPUT_NUM`: per-output packet end.
- `valid_o` output `OUTPUT_NUM`: per-output valid.
- `ready_i` input `OUTPUT_NUM`: per-output ready.
- `drop_count_o` output 16: saturating count of dropped packets.

## Operation
- FSM states: IDLE, ROUTE, DROP. Reset state is IDLE.
- `slot_ready[k] = !valid_o[k] || ready_i[k]`, where `valid_o[k]` is the slot's registered valid.
- **IDLE**
  - If `dest_i < OUTPUT_NUM`: `ready_o = slot_ready[dest_i]`.
  - On an accepted beat, the beat loads slot `dest_i` and `dest_q <= dest_i`.
  - If that beat has `last_i = 1`, stay in IDLE; otherwise go to ROUTE.
- **IDLE, invalid destination** (`dest_i >= OUTPUT_NUM`)
  - `ready_o = 1`; the beat is discarded.
  - `drop_count_o` increments, saturating at 0xFFFF.
  - If `last_i = 0`, go to DROP; otherwise stay in IDLE.
- **ROUTE**
  - `ready_o = slot_ready[dest_q]`.
  - `dest_i` is ignored.
  - An accepted beat loads slot `dest_q`. An accepted beat with `last_i = 1` returns the FSM to IDLE.
- **DROP**
  - `ready_o = 1`; all beats are discarded.
  - An accepted beat with `last_i = 1` returns the FSM to IDLE.
  - The counter does not increment again.
- **Output slots**
  - Each slot is a one-entry register holding {data, last, valid}.
  - Loading and draining in the same cycle is allowed, giving full throughput.
  - `data_o[k]` and `last_o[k]` hold their values while `valid_o[k] && !ready_i[k]`.
- Beats are never duplicated, reordered or lost, except beats of a dropped packet.
- Transitions happen only on an input handshake; `valid_i` low holds the state.

## Timing
- Latency: a beat accepted at edge N appears on `valid_o[k]` after edge N, one cycle.
- Throughput: one beat per cycle while the selected `ready_i` is high.
- Back-to-back packets to different outputs need no idle cycle. The last beat of packet A and the first beat of packet B are accepted on consecutive cycles.
- `ready_o` is combinational from `valid_i`-independent state plus `dest_i` and `ready_i`. It does not depend on `valid_i`.
- Reset values: `valid_o = 0`, `data_o = 0`, `last_o = 0`, `drop_count_o = 0`, state IDLE.
  - `ready_o = 0` while `ARESETn = 0`.
  - Reset asserted mid-packet discards slot contents and the route lock. After release, the next beat is treated as a first beat.

## Structure
- `axi_stream_pkg` holds the `router_state_t` enum {IDLE, ROUTE, DROP} and the drop-counter width constant (16).
- Sub-module `stream_reg`: the one-entry pipeline register with valid/ready and a data+last payload, instantiated `OUTPUT_NUM` times.
- `stream_router` contains the FSM, `dest_q`, the `ready_o` mux, the load enables and the counter.

## Test plan
- **Reset** (OUTPUT_NUM=4): hold `ARESETn` low 3 cycles with `valid_i = 1` → `ready_o = 0`, all `valid_o = 0`, `drop_count_o = 0`.
- **Locked route**: 3-beat packet, dest=2, data 0xA/0xB/0xC, last on 0xC, all `ready_i = 1`, and `dest_i` changed to 1 on beat 2.
  - Expect `valid_o[2]` on 3 consecutive cycles, one cycle after each accept, carrying 0xA, 0xB, 0xC.
  - Expect `last_o[2]` only with 0xC; `valid_o[0,1,3]` stays 0.
- **Backpressure**: the same packet with `ready_i[2] = 0` for 3 cycles after the first beat.
  - Expect 0xA held stable and `ready_o = 0` while the slot is full.
  - After release: 0xB, then 0xC, with no loss or duplication.
- **Back-to-back packets**: single-beat packets dest=0 (0x11) then dest=1 (0x22) on consecutive cycles.
  - Expect both accepted with no bubble; `valid_o[0]` and `valid_o[1]` each pulse one cycle, offset by one.
- **Invalid destination** (OUTPUT_NUM=3): 2-beat packet with dest=3.
  - Expect `ready_o = 1` on both beats, no `valid_o`, and `drop_count_o = 1`.
  - Then preload the counter path to 0xFFFF and drop again → stays 0xFFFF.
- **Reset mid-packet**: assert reset after beat 1 of a 3-beat dest=1 packet.
  - Expect `valid_o` cleared next cycle.
  - The post-reset beat with dest=0, `last = 1` routes to output 0.
